// File: rtl/frame_difference_channel.sv
// Frame-difference channel: a three-stage pipeline that computes the absolute
// difference between a current-frame pixel and its background-model pixel,
// flags it as foreground when the difference exceeds a per-pixel threshold,
// and (optionally) counts foreground pixels per frame.
//
// Optional feature macro: FRAME_DIFF_FG_COUNT_EN
//   defined   -> per-frame foreground accumulator drives fg_count/fg_count_valid
//   undefined -> fg_count and fg_count_valid are tied to 0
//
// Backpressure uses one global enable: every stage advances only when the
// output register is empty or being drained this cycle.

module frame_difference_channel #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       frame,
    input  logic [7:0]       background,
    input  logic             in_eof,
    input  logic [7:0]       threshold,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       odiff,
    output logic             omask,
    output logic             out_eof,
    output logic [CNT_W-1:0] fg_count,
    output logic             fg_count_valid
);

    logic             en;

    logic             s1_valid;
    logic [7:0]       s1_frame;
    logic [7:0]       s1_background;
    logic [7:0]       s1_threshold;
    logic             s1_eof;

    logic             s2_valid;
    logic [7:0]       s2_diff;
    logic [7:0]       s2_threshold;
    logic             s2_eof;

    logic signed [8:0] diff_signed;
    logic signed [8:0] diff_negated;
    logic [7:0]        diff_abs;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Absolute difference from a 9-bit signed subtraction; covers 0..255 exactly.
    always_comb begin
        diff_signed  = $signed({1'b0, s1_frame}) - $signed({1'b0, s1_background});
        diff_negated = -diff_signed;
        diff_abs     = diff_signed[8] ? diff_negated[7:0] : diff_signed[7:0];
    end

    // Stage 1: capture the incoming pixel, its threshold and end-of-frame marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_frame      <= 8'd0;
            s1_background <= 8'd0;
            s1_threshold  <= 8'd0;
            s1_eof        <= 1'b0;
        end else if (en) begin
            s1_valid      <= in_valid;
            s1_frame      <= frame;
            s1_background <= background;
            s1_threshold  <= threshold;
            s1_eof        <= in_eof;
        end
    end

    // Stage 2: register the absolute difference, carrying threshold and eof along.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid     <= 1'b0;
            s2_diff      <= 8'd0;
            s2_threshold <= 8'd0;
            s2_eof       <= 1'b0;
        end else if (en) begin
            s2_valid     <= s1_valid;
            s2_diff      <= diff_abs;
            s2_threshold <= s1_threshold;
            s2_eof       <= s1_eof;
        end
    end

    // Stage 3: output register with the strict-greater-than foreground decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            odiff     <= 8'd0;
            omask     <= 1'b0;
            out_eof   <= 1'b0;
        end else if (en) begin
            out_valid <= s2_valid;
            odiff     <= s2_diff;
            omask     <= s2_valid && (s2_diff > s2_threshold);
            out_eof   <= s2_valid && s2_eof;
        end
    end

`ifdef FRAME_DIFF_FG_COUNT_EN
    logic [CNT_W-1:0] fg_acc;
    logic [CNT_W-1:0] fg_acc_inc;
    logic             out_fire;

    assign out_fire = out_valid && out_ready;

    // Accumulator value including the pixel currently on the output, saturating.
    always_comb begin
        fg_acc_inc = fg_acc;
        if (omask && (fg_acc != {CNT_W{1'b1}})) begin
            fg_acc_inc = fg_acc + CNT_W'(1);
        end
    end

    // Count foreground transfers; publish and clear the count at end of frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fg_acc         <= '0;
            fg_count       <= '0;
            fg_count_valid <= 1'b0;
        end else begin
            fg_count_valid <= 1'b0;
            if (out_fire) begin
                if (out_eof) begin
                    fg_count       <= fg_acc_inc;
                    fg_count_valid <= 1'b1;
                    fg_acc         <= '0;
                end else begin
                    fg_acc <= fg_acc_inc;
                end
            end
        end
    end
`else
    assign fg_count       = '0;
    assign fg_count_valid = 1'b0;
`endif

endmodule
